// File: rtl/traffic_phase_sequencer.sv
// Main traffic-light phase FSM with per-second phase timers and run-time reprogrammable durations.
// Optional feature: define SENSOR_EXTEND_EN so the second green phases depend on sensor_in at entry.
module traffic_phase_sequencer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter logic [3:0]  T_BASE   = 4'd6,
  parameter logic [3:0]  T_EXT    = 4'd3,
  parameter logic [3:0]  T_YEL    = 4'd2
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       reset_db_in,
  input  logic       walk_req_db_in,
  input  logic       reprog_db_in,
  input  logic       sensor_in,
  input  logic [1:0] time_sel,
  input  logic [3:0] time_val,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_out,
  output logic [2:0] phase
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [2:0] L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001;

  typedef enum logic [2:0] {
    MAIN_G1 = 3'd0, MAIN_G2 = 3'd1, MAIN_Y  = 3'd2, WALK = 3'd3,
    SIDE_G1 = 3'd4, SIDE_G2 = 3'd5, SIDE_Y  = 3'd6
  } state_t;

  state_t          r_state, w_state_n;
  logic [PW-1:0]   r_presc;
  logic [3:0]      r_timer, r_base, r_ext, r_yel;
  logic [3:0]      w_base_n, w_ext_n, w_yel_n, w_dur, w_load;
  logic            r_walk;
  logic            w_tick, w_expire, w_restart, w_enter;
  logic [2:0]      w_main, w_side;
  logic            w_walk;

  assign w_tick    = (r_presc == PW'(TICK_DIV - 1));
  assign w_expire  = w_tick && (r_timer == 4'd1);
  assign w_restart = reset_db_in || reprog_db_in;
  assign w_enter   = w_restart || (w_state_n != r_state);

  // Duration registers after this cycle's reprogram write, so a restart loads fresh values.
  always_comb begin
    w_base_n = r_base;
    w_ext_n  = r_ext;
    w_yel_n  = r_yel;
    if (reprog_db_in) begin
      case (time_sel)
        2'd0:    w_base_n = time_val;
        2'd1:    w_ext_n  = time_val;
        2'd2:    w_yel_n  = time_val;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_main    = L_R;
    w_side    = L_R;
    w_walk    = 1'b0;
    if (w_restart) begin
      w_state_n = MAIN_G1;
    end else begin
      case (r_state)
        MAIN_G1: if (w_expire) w_state_n = MAIN_G2;
        MAIN_G2: if (w_expire) w_state_n = MAIN_Y;
        MAIN_Y:  if (w_expire) w_state_n = r_walk ? WALK : SIDE_G1;
        WALK:    if (w_expire) w_state_n = SIDE_G1;
        SIDE_G1: if (w_expire) w_state_n = SIDE_G2;
        SIDE_G2: if (w_expire) w_state_n = SIDE_Y;
        SIDE_Y:  if (w_expire) w_state_n = MAIN_G1;
        default: w_state_n = MAIN_G1;
      endcase
    end
    // Lights are decoded from the next state so the registered outputs track r_state.
    case (w_state_n)
      MAIN_G1, MAIN_G2: w_main = L_G;
      MAIN_Y:           w_main = L_Y;
      WALK:             w_walk = 1'b1;
      SIDE_G1, SIDE_G2: w_side = L_G;
      SIDE_Y:           w_side = L_Y;
      default:          ;
    endcase
  end

  always_comb begin
    case (w_state_n)
      MAIN_G1, SIDE_G1: w_dur = w_base_n;
`ifdef SENSOR_EXTEND_EN
      MAIN_G2, SIDE_G2: w_dur = sensor_in ? w_ext_n : 4'd1;
`else
      MAIN_G2, SIDE_G2: w_dur = w_ext_n;
`endif
      WALK:             w_dur = w_ext_n;
      default:          w_dur = w_yel_n;
    endcase
    w_load = (w_dur == 4'd0) ? 4'd1 : w_dur;
  end

`ifndef SENSOR_EXTEND_EN
  logic w_unused_sensor;
  assign w_unused_sensor = sensor_in;
`endif

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_state    <= MAIN_G1;
      main_light <= L_G;
      side_light <= L_R;
      walk_out   <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      main_light <= w_main;
      side_light <= w_side;
      walk_out   <= w_walk;
    end
  end

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_presc <= '0;
      r_timer <= (T_BASE == 4'd0) ? 4'd1 : T_BASE;
      r_base  <= T_BASE;
      r_ext   <= T_EXT;
      r_yel   <= T_YEL;
      r_walk  <= 1'b0;
    end else begin
      r_base <= w_base_n;
      r_ext  <= w_ext_n;
      r_yel  <= w_yel_n;
      if (w_enter) begin
        r_presc <= '0;
        r_timer <= w_load;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) r_timer <= r_timer - 4'd1;
      end
      // Entering WALK consumes the request; requests during WALK are dropped.
      if (reset_db_in)
        r_walk <= 1'b0;
      else if (w_enter && (w_state_n == WALK))
        r_walk <= 1'b0;
      else if (walk_req_db_in && (r_state != WALK))
        r_walk <= 1'b1;
    end
  end

  assign phase = r_state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer at TICK_DIV=4 with default durations 6/3/2.
module tb_traffic_phase_sequencer;

`ifdef SENSOR_EXTEND_EN
  localparam int G2S0 = 4;
`else
  localparam int G2S0 = 12;
`endif
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  logic       clk, sys_reset, reset_db_in, walk_req_db_in, reprog_db_in, sensor_in;
  logic [1:0] time_sel;
  logic [3:0] time_val;
  logic [2:0] main_light, side_light, phase;
  logic       walk_out;

  int total = 0;
  int bad   = 0;

  traffic_phase_sequencer #(.TICK_DIV(4), .T_BASE(4'd6), .T_EXT(4'd3), .T_YEL(4'd2)) dut (
    .clk(clk), .sys_reset(sys_reset), .reset_db_in(reset_db_in),
    .walk_req_db_in(walk_req_db_in), .reprog_db_in(reprog_db_in), .sensor_in(sensor_in),
    .time_sel(time_sel), .time_val(time_val), .main_light(main_light),
    .side_light(side_light), .walk_out(walk_out), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sensor;
    logic [2:0] ph;
    logic [2:0] ml;
    logic [2:0] sl;
    logic       wk;
    int         len;
  } seg_t;

  seg_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [2:0] ph, input logic [2:0] ml,
                          input logic [2:0] sl, input logic wk);
    chk(nm, 32'({phase, main_light, side_light, walk_out}), 32'({ph, ml, sl, wk}));
  endtask

  // Called at the negedge of the first cycle to be counted; returns at the first cycle of the next phase.
  task automatic run_seg(input logic [2:0] ph, input logic [2:0] ml, input logic [2:0] sl,
                         input logic wk, input int len, input string nm);
    int n;
    chk_outs({nm, " outs"}, ph, ml, sl, wk);
    n = 0;
    do begin
      n++;
      @(negedge clk);
    end while (phase == ph && n < 300);
    chk({nm, " len"}, 32'(n), 32'(len));
  endtask

  task automatic pulse_walk();
    walk_req_db_in = 1'b1;
    @(negedge clk);
    walk_req_db_in = 1'b0;
  endtask

  task automatic do_reprog(input logic [1:0] sel, input logic [3:0] val);
    time_sel     = sel;
    time_val     = val;
    reprog_db_in = 1'b1;
    @(negedge clk);
    reprog_db_in = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 3'd0, G, R, 1'b0, 24};
    tbl[1]  = '{1'b0, 3'd1, G, R, 1'b0, G2S0};
    tbl[2]  = '{1'b0, 3'd2, Y, R, 1'b0, 8};
    tbl[3]  = '{1'b0, 3'd4, R, G, 1'b0, 24};
    tbl[4]  = '{1'b0, 3'd5, R, G, 1'b0, G2S0};
    tbl[5]  = '{1'b0, 3'd6, R, Y, 1'b0, 8};
    tbl[6]  = '{1'b1, 3'd0, G, R, 1'b0, 24};
    tbl[7]  = '{1'b1, 3'd1, G, R, 1'b0, 12};
    tbl[8]  = '{1'b1, 3'd2, Y, R, 1'b0, 8};
    tbl[9]  = '{1'b1, 3'd4, R, G, 1'b0, 24};
    tbl[10] = '{1'b1, 3'd5, R, G, 1'b0, 12};
    tbl[11] = '{1'b1, 3'd6, R, Y, 1'b0, 8};

    sys_reset = 1'b0; reset_db_in = 1'b0; walk_req_db_in = 1'b0;
    reprog_db_in = 1'b0; sensor_in = 1'b0; time_sel = 2'd3; time_val = 4'd0;
    repeat (3) @(negedge clk);
    chk_outs("reset state", 3'd0, G, R, 1'b0);
    sys_reset = 1'b1;

    // Full cycles without and with the side sensor
    for (int i = 0; i < 12; i++) begin
      sensor_in = tbl[i].sensor;
      run_seg(tbl[i].ph, tbl[i].ml, tbl[i].sl, tbl[i].wk, tbl[i].len, $sformatf("tbl%0d", i));
    end
    sensor_in = 1'b0;

    // Walk request in MAIN_G1 is served after MAIN_Y; a request during WALK is dropped
    pulse_walk();
    run_seg(3'd0, G, R, 1'b0, 23, "w main_g1");
    run_seg(3'd1, G, R, 1'b0, G2S0, "w main_g2");
    run_seg(3'd2, Y, R, 1'b0, 8, "w main_y");
    chk_outs("w walk entry", 3'd3, R, R, 1'b1);
    pulse_walk();
    run_seg(3'd3, R, R, 1'b1, 11, "w walk");
    run_seg(3'd4, R, G, 1'b0, 24, "w side_g1");
    run_seg(3'd5, R, G, 1'b0, G2S0, "w side_g2");
    run_seg(3'd6, R, Y, 1'b0, 8, "w side_y");
    run_seg(3'd0, G, R, 1'b0, 24, "w2 main_g1");
    run_seg(3'd1, G, R, 1'b0, G2S0, "w2 main_g2");
    run_seg(3'd2, Y, R, 1'b0, 8, "w2 main_y");

    // Reprogram yellow to 5 mid SIDE_G1, then sel=3 restart, then yellow=0 acts as 1
    chk_outs("rp side_g1", 3'd4, R, G, 1'b0);
    repeat (5) @(negedge clk);
    do_reprog(2'd2, 4'd5);
    run_seg(3'd0, G, R, 1'b0, 24, "rp main_g1");
    run_seg(3'd1, G, R, 1'b0, G2S0, "rp main_g2");
    run_seg(3'd2, Y, R, 1'b0, 20, "rp main_y");
    repeat (3) @(negedge clk);
    do_reprog(2'd3, 4'd0);
    run_seg(3'd0, G, R, 1'b0, 24, "rp3 main_g1");
    run_seg(3'd1, G, R, 1'b0, G2S0, "rp3 main_g2");
    run_seg(3'd2, Y, R, 1'b0, 20, "rp3 main_y");
    run_seg(3'd4, R, G, 1'b0, 24, "rp3 side_g1");
    do_reprog(2'd2, 4'd0);
    run_seg(3'd0, G, R, 1'b0, 24, "rp0 main_g1");
    run_seg(3'd1, G, R, 1'b0, G2S0, "rp0 main_g2");
    run_seg(3'd2, Y, R, 1'b0, 4, "rp0 main_y");
    do_reprog(2'd2, 4'd2);

    // Held sync restart in SIDE_Y with walk latched: stays MAIN_G1, latch cleared
    run_seg(3'd0, G, R, 1'b0, 24, "rs main_g1");
    run_seg(3'd1, G, R, 1'b0, G2S0, "rs main_g2");
    run_seg(3'd2, Y, R, 1'b0, 8, "rs main_y");
    pulse_walk();
    run_seg(3'd4, R, G, 1'b0, 23, "rs side_g1");
    run_seg(3'd5, R, G, 1'b0, G2S0, "rs side_g2");
    chk_outs("rs side_y", 3'd6, R, Y, 1'b0);
    reset_db_in = 1'b1;
    repeat (5) @(negedge clk);
    chk_outs("rs held", 3'd0, G, R, 1'b0);
    repeat (5) @(negedge clk);
    reset_db_in = 1'b0;
    run_seg(3'd0, G, R, 1'b0, 24, "rs2 main_g1");
    run_seg(3'd1, G, R, 1'b0, G2S0, "rs2 main_g2");
    run_seg(3'd2, Y, R, 1'b0, 8, "rs2 main_y");
    run_seg(3'd4, R, G, 1'b0, 24, "rs2 side_g1");

    // Simultaneous restart and reprogram: base=2 written, walk latch cleared
    pulse_walk();
    reset_db_in = 1'b1;
    do_reprog(2'd0, 4'd2);
    reset_db_in = 1'b0;
    run_seg(3'd0, G, R, 1'b0, 8, "sim main_g1");
    run_seg(3'd1, G, R, 1'b0, G2S0, "sim main_g2");
    run_seg(3'd2, Y, R, 1'b0, 8, "sim main_y");
    run_seg(3'd4, R, G, 1'b0, 8, "sim side_g1");

    // Async reset mid-WALK after base=9 restores defaults
    do_reprog(2'd0, 4'd9);
    pulse_walk();
    run_seg(3'd0, G, R, 1'b0, 35, "ar main_g1");
    run_seg(3'd1, G, R, 1'b0, G2S0, "ar main_g2");
    run_seg(3'd2, Y, R, 1'b0, 8, "ar main_y");
    chk_outs("ar walk", 3'd3, R, R, 1'b1);
    repeat (3) @(negedge clk);
    #2 sys_reset = 1'b0;
    #1 chk_outs("ar async", 3'd0, G, R, 1'b0);
    @(negedge clk);
    sys_reset = 1'b1;
    run_seg(3'd0, G, R, 1'b0, 24, "ar2 main_g1");
    run_seg(3'd1, G, R, 1'b0, G2S0, "ar2 main_g2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
